// File: rtl/genius_pkg.sv
// Shared definitions for the sequence-memory game datapath.
//   clog2()     : ceiling log2, used to size counters and the address bus
//   onehot()    : index (0..7) -> 8-bit one-hot play pattern
//   reduz_mod() : small modulo by repeated conditional subtraction
//   LFSR mask/default seed, timer length multipliers, LED source enum
package genius_pkg;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Timer lengths in seconds (multiples of CLOCK_FREQ)
    localparam int MULT_DISPLAY     = 1;
    localparam int MULT_TEMPO_CURTO = 3;
    localparam int MULT_TEMPO_LONGO = 5;

    typedef enum logic [1:0] {
        LED_OFF = 2'd0,
        LED_MEM = 2'd1,
        LED_JOG = 2'd2
    } fonte_led_e;

    function automatic int clog2(input int valor);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < valor) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] k);
        return 8'b0000_0001 << k;
    endfunction

    // v (0..7) mod n for n in 2..8; three subtractions cover the n = 2 worst case
    function automatic logic [2:0] reduz_mod(input logic [2:0] v, input int n);
        logic [2:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (int'(r) >= n) begin
                r = r - 3'(n);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fluxo_dados_sequencia_n_if.sv
// Control/condition bundle between the game control FSM (master) and the
// datapath (slave). Master drives buttons, configuration and control strobes;
// slave returns the condition flags, LED drive and debug views.
interface fluxo_dados_sequencia_n_if #(
    parameter int N_BOTOES = 4,
    parameter int AW       = 4
);
    // control side -> datapath
    logic [N_BOTOES-1:0] botoes;
    logic                nivel_jogadas;
    logic                nivel_tempo;
    logic                modo_aleatorio;
    logic                registraN;
    logic                registraR;
    logic                zeraC;
    logic                contaC;
    logic                zeraCR;
    logic                contaCR;
    logic                zeraTM;
    logic                contaTM;
    logic                zeraTempo;
    logic                contaTempo;
    logic                gravaM;
    logic                gravaAleatorio;
    logic                ativa_leds_mem;
    logic                ativa_leds_jog;

    // datapath -> control side
    logic                jogada_feita;
    logic                jogada_valida;
    logic                jogada_correta;
    logic                enderecoIgualRodada;
    logic                fimC;
    logic                fimCR;
    logic                fimTM;
    logic                meioTM;
    logic                fimTempo;
    logic                meioTempo;
    logic                nivel_jogadas_reg;
    logic                nivel_tempo_reg;
    logic                modo_aleatorio_reg;
    logic [N_BOTOES-1:0] leds;
    logic [AW-1:0]       db_endereco;
    logic [AW-1:0]       db_rodada;
    logic [N_BOTOES-1:0] db_jogada;
    logic [N_BOTOES-1:0] db_memoria;

    modport master (
        output botoes, nivel_jogadas, nivel_tempo, modo_aleatorio,
               registraN, registraR, zeraC, contaC, zeraCR, contaCR,
               zeraTM, contaTM, zeraTempo, contaTempo, gravaM, gravaAleatorio,
               ativa_leds_mem, ativa_leds_jog,
        input  jogada_feita, jogada_valida, jogada_correta, enderecoIgualRodada,
               fimC, fimCR, fimTM, meioTM, fimTempo, meioTempo,
               nivel_jogadas_reg, nivel_tempo_reg, modo_aleatorio_reg,
               leds, db_endereco, db_rodada, db_jogada, db_memoria
    );

    modport slave (
        input  botoes, nivel_jogadas, nivel_tempo, modo_aleatorio,
               registraN, registraR, zeraC, contaC, zeraCR, contaCR,
               zeraTM, contaTM, zeraTempo, contaTempo, gravaM, gravaAleatorio,
               ativa_leds_mem, ativa_leds_jog,
        output jogada_feita, jogada_valida, jogada_correta, enderecoIgualRodada,
               fimC, fimCR, fimTM, meioTM, fimTempo, meioTempo,
               nivel_jogadas_reg, nivel_tempo_reg, modo_aleatorio_reg,
               leds, db_endereco, db_rodada, db_jogada, db_memoria
    );
endinterface

// File: rtl/contador_m.sv
// Modulo counter with synchronous clear; the wrap point is a run-time input
// so the timeout timer can switch between lengths.
//   zera_i   : clear (priority over conta_i)
//   conta_i  : count enable; wraps to 0 after ultimo_i
//   ultimo_i : M-1,  metade_i : M/2
//   q_o, fim_o (q == M-1), meio_o (q == M/2)
module contador_m #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera_i,
    input  logic         conta_i,
    input  logic [W-1:0] ultimo_i,
    input  logic [W-1:0] metade_i,
    output logic [W-1:0] q_o,
    output logic         fim_o,
    output logic         meio_o
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (zera_i) begin
            q_d = '0;
        end else if (conta_i) begin
            // ">=" so a shortened modulus never leaves the count stranded above it
            q_d = (q_q >= ultimo_i) ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign fim_o  = (q_q == ultimo_i);
    assign meio_o = (q_q == metade_i);
endmodule

// File: rtl/gerador_lfsr.sv
// Free-running 16-bit Galois LFSR, shifting right every cycle.
//   clock, reset : clock / synchronous active-high reset (loads SEED)
//   estado_o     : current LFSR state
module gerador_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] estado_o
);
    logic [15:0] estado_q;
    logic [15:0] estado_d;

    always_comb begin
        estado_d = {1'b0, estado_q[15:1]} ^ (estado_q[0] ? MASK : 16'h0000);
        // All-zero is a lock-up state for an XOR LFSR; recover from it
        if (estado_q == 16'h0000) begin
            estado_d = SEED;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= SEED;
        end else begin
            estado_q <= estado_d;
        end
    end

    assign estado_o = estado_q;
endmodule

// File: rtl/fluxo_dados_sequencia_n.sv
// Parametrised datapath for the sequence-memory game.
//   clock, reset : clock / synchronous active-high reset
//   bus (slave)  : control strobes and buttons in; condition flags, LEDs and
//                  debug views out
// Holds the sequence memory, configuration/play registers, press edge
// detector, address and round counters, display and timeout timers and a
// free-running LFSR used to generate random plays.
module fluxo_dados_sequencia_n
    import genius_pkg::*;
#(
    parameter int          N_BOTOES   = 4,
    parameter int          PROF       = 16,
    parameter int          CLOCK_FREQ = 5000,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    fluxo_dados_sequencia_n_if.slave bus
);
    localparam int AW      = clog2(PROF);
    localparam int M_TM    = CLOCK_FREQ * MULT_DISPLAY;
    localparam int M_CURTO = CLOCK_FREQ * MULT_TEMPO_CURTO;
    localparam int M_LONGO = CLOCK_FREQ * MULT_TEMPO_LONGO;
    localparam int TM_W    = clog2(M_TM + 1);
    localparam int TEMPO_W = clog2(M_LONGO + 1);

    logic                nivel_jogadas_q;
    logic                nivel_tempo_q;
    logic                modo_aleatorio_q;
    logic [N_BOTOES-1:0] jogada_q;
    logic                botao_prev_q;
    logic [AW-1:0]       rodada_q;
    logic [AW-1:0]       rodada_d;
    logic [AW-1:0]       limite_rodada;

    logic                alguma_tecla;
    logic                jogada_feita;
    logic [AW-1:0]       endereco;
    logic [15:0]         lfsr;
    logic [N_BOTOES-1:0] jogada_lfsr;
    logic [N_BOTOES-1:0] memoria;
    logic [N_BOTOES-1:0] dado_escrita;
    logic                escreve;
    logic [N_BOTOES-1:0] mem_palavras [PROF];

    logic [TEMPO_W-1:0]  tempo_ultimo;
    logic [TEMPO_W-1:0]  tempo_metade;
    logic [TM_W-1:0]     q_tm;
    logic [TEMPO_W-1:0]  q_tempo;
    logic                meio_endereco;
    logic                sinais_unused;
    fonte_led_e          fonte_led;

    // ---------------- press edge detector ----------------
    assign alguma_tecla = |bus.botoes;
    assign jogada_feita = alguma_tecla & ~botao_prev_q;

    // ---------------- LFSR and derived random play ----------------
    gerador_lfsr #(
        .SEED (LFSR_SEED),
        .MASK (LFSR_MASK)
    ) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .estado_o (lfsr)
    );

    assign jogada_lfsr = N_BOTOES'(onehot(reduz_mod(lfsr[2:0], N_BOTOES)));

    // ---------------- registers ----------------
    always_comb begin
        limite_rodada = nivel_jogadas_q ? AW'(PROF - 1) : AW'(PROF / 2 - 1);
        rodada_d      = rodada_q;
        if (bus.zeraCR) begin
            rodada_d = '0;
        end else if (bus.contaCR && (rodada_q < limite_rodada)) begin
            rodada_d = rodada_q + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            nivel_jogadas_q  <= 1'b0;
            nivel_tempo_q    <= 1'b0;
            modo_aleatorio_q <= 1'b0;
            jogada_q         <= '0;
            botao_prev_q     <= 1'b0;
            rodada_q         <= '0;
        end else begin
            if (bus.registraN) begin
                nivel_jogadas_q  <= bus.nivel_jogadas;
                nivel_tempo_q    <= bus.nivel_tempo;
                modo_aleatorio_q <= bus.modo_aleatorio;
            end
            if (bus.registraR) begin
                jogada_q <= bus.botoes;
            end
            botao_prev_q <= alguma_tecla;
            rodada_q     <= rodada_d;
        end
    end

    // ---------------- counters and timers ----------------
    contador_m #(.W(AW)) u_cont_endereco (
        .clock    (clock),
        .reset    (reset),
        .zera_i   (bus.zeraC),
        .conta_i  (bus.contaC),
        .ultimo_i (AW'(PROF - 1)),
        .metade_i (AW'(PROF / 2)),
        .q_o      (endereco),
        .fim_o    (bus.fimC),
        .meio_o   (meio_endereco)
    );

    contador_m #(.W(TM_W)) u_timer_display (
        .clock    (clock),
        .reset    (reset),
        .zera_i   (bus.zeraTM),
        .conta_i  (bus.contaTM),
        .ultimo_i (TM_W'(M_TM - 1)),
        .metade_i (TM_W'(M_TM / 2)),
        .q_o      (q_tm),
        .fim_o    (bus.fimTM),
        .meio_o   (bus.meioTM)
    );

    assign tempo_ultimo = nivel_tempo_q ? TEMPO_W'(M_CURTO - 1) : TEMPO_W'(M_LONGO - 1);
    assign tempo_metade = nivel_tempo_q ? TEMPO_W'(M_CURTO / 2) : TEMPO_W'(M_LONGO / 2);

    // A new press restarts the timeout window; an explicit clear still wins
    contador_m #(.W(TEMPO_W)) u_timer_tempo (
        .clock    (clock),
        .reset    (reset),
        .zera_i   (bus.zeraTempo | jogada_feita),
        .conta_i  (bus.contaTempo),
        .ultimo_i (tempo_ultimo),
        .metade_i (tempo_metade),
        .q_o      (q_tempo),
        .fim_o    (bus.fimTempo),
        .meio_o   (bus.meioTempo)
    );

    // ---------------- sequence memory ----------------
    always_comb begin
        escreve      = 1'b0;
        dado_escrita = jogada_q;
        if (!reset) begin
            if (bus.gravaM) begin
                escreve      = 1'b1;
                dado_escrita = jogada_q;
            end else if (bus.gravaAleatorio && modo_aleatorio_q) begin
                escreve      = 1'b1;
                dado_escrita = jogada_lfsr;
            end
        end
    end

    // One register per word, power-up value one-hot(i mod N_BOTOES); reset
    // deliberately leaves the stored sequence alone.
    for (genvar gi = 0; gi < PROF; gi++) begin : g_mem
        logic [N_BOTOES-1:0] palavra_q = N_BOTOES'(onehot(3'(gi % N_BOTOES)));

        always_ff @(posedge clock) begin
            if (escreve && (endereco == AW'(gi))) begin
                palavra_q <= dado_escrita;
            end
        end

        assign mem_palavras[gi] = palavra_q;
    end

    assign memoria = mem_palavras[endereco];

    // ---------------- LED source ----------------
    always_comb begin
        fonte_led = LED_OFF;
        if (bus.ativa_leds_mem) begin
            fonte_led = LED_MEM;
        end else if (bus.ativa_leds_jog) begin
            fonte_led = LED_JOG;
        end
    end

    always_comb begin
        case (fonte_led)
            LED_MEM: bus.leds = memoria;
            LED_JOG: bus.leds = jogada_q;
            default: bus.leds = '0;
        endcase
    end

    // ---------------- condition / debug outputs ----------------
    assign bus.jogada_feita        = jogada_feita;
    assign bus.jogada_valida       = (jogada_q != '0) &&
                                     ((jogada_q & (jogada_q - N_BOTOES'(1))) == '0);
    assign bus.jogada_correta      = (memoria == jogada_q);
    assign bus.enderecoIgualRodada = (endereco == rodada_q);
    assign bus.fimCR               = (rodada_q == limite_rodada);
    assign bus.nivel_jogadas_reg   = nivel_jogadas_q;
    assign bus.nivel_tempo_reg     = nivel_tempo_q;
    assign bus.modo_aleatorio_reg  = modo_aleatorio_q;
    assign bus.db_endereco         = endereco;
    assign bus.db_rodada           = rodada_q;
    assign bus.db_jogada           = jogada_q;
    assign bus.db_memoria          = memoria;

    // Timer counts and upper LFSR bits are internal only
    assign sinais_unused = ^{lfsr[15:3], q_tm, q_tempo, meio_endereco};
endmodule
